// File: rtl/fifo_rd_arb_pkg.sv
// Shared types and helpers for the FIFO read-port arbiter.
package fifo_rd_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    // Width of a consumer index; a single-bit field is kept even for tiny NREQ.
    function automatic int id_width(input int nreq);
        return (nreq > 2) ? $clog2(nreq) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority encoder: first set req bit at or after last_gnt+1, wrapping modulo NREQ.
module rr_pick
    import fifo_rd_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last_gnt,
    output logic            found,
    output logic [IW-1:0]   idx
);

    logic [IW-1:0] cand;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        // Scan farthest-to-nearest so the nearest requester is the last writer and wins.
        for (int i = NREQ; i >= 1; i--) begin
            cand = IW'((int'(last_gnt) + i >= NREQ) ? int'(last_gnt) + i - NREQ
                                                    : int'(last_gnt) + i);
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// Round-robin burst arbiter sharing one async-FIFO read port among NREQ consumers.
module fifo_rd_arbiter
    import fifo_rd_arb_pkg::*;
#(
    parameter int DSIZE    = 8,
    parameter int NREQ     = 4,
    parameter int MAXBURST = 8
) (
    input  logic                        rclk,
    input  logic                        rrst,
    input  logic                        rempty,
    input  logic [DSIZE-1:0]            rdata,
    output logic                        rinc,
    input  logic [NREQ-1:0]             req,
    input  logic [NREQ-1:0]             rdy,
    output logic [NREQ-1:0]             gnt,
    output logic                        out_valid,
    output logic [DSIZE-1:0]            out_data,
    output logic [id_width(NREQ)-1:0]   out_id,
    output logic                        busy
);

    localparam int IW = id_width(NREQ);
    localparam int CW = $clog2(MAXBURST + 1);

    arb_state_t      state;
    logic [IW-1:0]   gid;
    logic [IW-1:0]   last_gnt;
    logic [CW-1:0]   cnt;

    logic            pick_found;
    logic [IW-1:0]   pick_idx;
    logic            burst_done;
    logic            burst_exit;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .req      (req),
        .last_gnt (last_gnt),
        .found    (pick_found),
        .idx      (pick_idx)
    );

    // Pop only into a live, ready grant; an async reset drops state and so rinc at once.
    assign rinc       = (state == BURST) && !rempty && req[gid] && rdy[gid];
    assign burst_done = rinc && (cnt == CW'(MAXBURST - 1));
    assign burst_exit = burst_done || !req[gid] || rempty;

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            state     <= IDLE;
            gid       <= '0;
            last_gnt  <= IW'(NREQ - 1);
            cnt       <= '0;
            gnt       <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            out_valid <= rinc;
            if (rinc) begin
                out_data <= rdata;
                out_id   <= gid;
            end

            case (state)
                IDLE: begin
                    if (pick_found && !rempty) begin
                        gid   <= pick_idx;
                        gnt   <= NREQ'(1) << pick_idx;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= BURST;
                    end
                end
                BURST: begin
                    if (rinc) begin
                        cnt <= cnt + CW'(1);
                    end
                    if (burst_exit) begin
                        gnt      <= '0;
                        busy     <= 1'b0;
                        last_gnt <= gid;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Self-checking bench: FIFO model feeds the arbiter, a scoreboard checks forwarded words.
module tb_fifo_rd_arbiter;

    localparam int DSIZE    = 8;
    localparam int NREQ     = 4;
    localparam int MAXBURST = 8;

    typedef struct packed {
        logic [1:0]       id;
        logic [DSIZE-1:0] data;
    } sb_entry_t;

    logic             rclk = 1'b0;
    logic             rrst = 1'b0;
    logic             rempty = 1'b1;
    logic [DSIZE-1:0] rdata = '0;
    logic             rinc;
    logic [NREQ-1:0]  req = '0;
    logic [NREQ-1:0]  rdy = '1;
    logic [NREQ-1:0]  gnt;
    logic             out_valid;
    logic [DSIZE-1:0] out_data;
    logic [1:0]       out_id;
    logic             busy;

    logic [DSIZE-1:0] fifo[$];
    sb_entry_t        sb[$];
    logic [DSIZE-1:0] next_word = 8'h10;
    logic             auto_fill = 1'b0;
    int               errors = 0;
    int               checks = 0;

    fifo_rd_arbiter #(
        .DSIZE    (DSIZE),
        .NREQ     (NREQ),
        .MAXBURST (MAXBURST)
    ) dut (
        .rclk      (rclk),
        .rrst      (rrst),
        .rempty    (rempty),
        .rdata     (rdata),
        .rinc      (rinc),
        .req       (req),
        .rdy       (rdy),
        .gnt       (gnt),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .busy      (busy)
    );

    always #5 rclk = ~rclk;

    task automatic update_fifo_outputs();
        rempty = (fifo.size() == 0);
        rdata  = rempty ? '0 : fifo[0];
    endtask

    task automatic load_words(input int n);
        for (int i = 0; i < n; i++) begin
            fifo.push_back(next_word);
            next_word = next_word + 8'd1;
        end
        update_fifo_outputs();
    endtask

    // One clock cycle: check rinc/gnt mid-cycle, model the pop, then check the registered output.
    task automatic step(input logic exp_rinc, input logic [NREQ-1:0] exp_gnt,
                        input int exp_id, input string tag);
        logic             popped;
        logic [DSIZE-1:0] w;
        sb_entry_t        e;
        #2;
        checks++;
        if (rinc !== exp_rinc) begin
            errors++;
            $display("FAIL %s rinc: got %b expected %b at %0t", tag, rinc, exp_rinc, $time);
        end
        checks++;
        if (gnt !== exp_gnt) begin
            errors++;
            $display("FAIL %s gnt: got %b expected %b at %0t", tag, gnt, exp_gnt, $time);
        end
        popped = 1'b0;
        if (rinc === 1'b1) begin
            if (fifo.size() == 0) begin
                errors++;
                $display("FAIL %s underflow: rinc while model FIFO empty", tag);
            end else begin
                w = fifo.pop_front();
                sb.push_back('{id: 2'(exp_id), data: w});
                popped = 1'b1;
            end
        end
        @(posedge rclk);
        #1;
        if (auto_fill) begin
            while (fifo.size() < 4) begin
                fifo.push_back(next_word);
                next_word = next_word + 8'd1;
            end
        end
        update_fifo_outputs();
        checks++;
        if (out_valid !== popped) begin
            errors++;
            $display("FAIL %s out_valid: got %b expected %b at %0t", tag, out_valid, popped, $time);
        end
        if (out_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL %s word: got id=%0d data=%h expected nothing", tag, out_id, out_data);
            end else begin
                e = sb.pop_front();
                if ({out_id, out_data} !== e) begin
                    errors++;
                    $display("FAIL %s word: got id=%0d data=%h expected id=%0d data=%h",
                             tag, out_id, out_data, e.id, e.data);
                end
            end
        end
    endtask

    task automatic pulse_reset();
        rrst = 1'b1;
        @(posedge rclk);
        #1;
        rrst = 1'b0;
    endtask

    task automatic test_reset();
        req  = '0;
        rdy  = '1;
        rrst = 1'b1;
        #2;
        checks++;
        if ({gnt, busy, out_valid, rinc} !== 7'b0) begin
            errors++;
            $display("FAIL reset ctrl: got gnt=%b busy=%b out_valid=%b rinc=%b expected zeros",
                     gnt, busy, out_valid, rinc);
        end
        checks++;
        if ({out_id, out_data} !== 10'b0) begin
            errors++;
            $display("FAIL reset data: got id=%0d data=%h expected 0/00", out_id, out_data);
        end
        @(posedge rclk);
        #1;
        rrst = 1'b0;
    endtask

    task automatic test_single_long();
        load_words(20);
        req = 4'b0001;
        for (int b = 0; b < 3; b++) begin
            step(1'b0, 4'b0000, 0, "sc_gap");
            for (int i = 0; i < ((b == 2) ? 4 : 8); i++) step(1'b1, 4'b0001, 0, "sc_pop");
        end
        step(1'b0, 4'b0001, 0, "sc_drain");
        step(1'b0, 4'b0000, 0, "sc_idle");
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL sc_busy: got %b expected 0", busy);
        end
        req = '0;
    endtask

    task automatic test_round_robin();
        int seq[5] = '{0, 1, 2, 3, 0};
        pulse_reset();
        auto_fill = 1'b1;
        load_words(4);
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            step(1'b0, 4'b0000, 0, "rr_gap");
            for (int i = 0; i < MAXBURST; i++)
                step(1'b1, NREQ'(1) << seq[g], seq[g], "rr_pop");
        end
        req = '0;
    endtask

    task automatic test_backpressure();
        req = 4'b0100;
        step(1'b0, 4'b0000, 0, "bp_gap");
        for (int i = 0; i < 3; i++) step(1'b1, 4'b0100, 2, "bp_pop");
        rdy = 4'b1011;
        for (int i = 0; i < 5; i++) step(1'b0, 4'b0100, 2, "bp_stall");
        rdy = 4'b1111;
        for (int i = 0; i < 5; i++) step(1'b1, 4'b0100, 2, "bp_resume");
        req = '0;
        step(1'b0, 4'b0000, 0, "bp_done");
    endtask

    task automatic test_withdraw();
        req = 4'b0110;
        step(1'b0, 4'b0000, 0, "wd_gap");
        for (int i = 0; i < 3; i++) step(1'b1, 4'b0010, 1, "wd_pop");
        req = 4'b0100;
        step(1'b0, 4'b0010, 0, "wd_exit");
        step(1'b0, 4'b0000, 0, "wd_gap2");
        step(1'b1, 4'b0100, 2, "wd_next");
        req = '0;
        step(1'b0, 4'b0100, 0, "wd_exit2");
        step(1'b0, 4'b0000, 0, "wd_idle");
    endtask

    task automatic test_empty();
        auto_fill = 1'b0;
        fifo.delete();
        load_words(2);
        req = 4'b0001;
        step(1'b0, 4'b0000, 0, "em_gap");
        step(1'b1, 4'b0001, 0, "em_pop");
        step(1'b1, 4'b0001, 0, "em_pop");
        step(1'b0, 4'b0001, 0, "em_drain");
        step(1'b0, 4'b0000, 0, "em_idle");
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL em_busy: got %b expected 0", busy);
        end
        req = '0;
    endtask

    task automatic test_reset_mid_burst();
        auto_fill = 1'b1;
        load_words(4);
        req = 4'b1111;
        step(1'b0, 4'b0000, 0, "rm_gap");
        for (int i = 0; i < 4; i++) step(1'b1, 4'b0010, 1, "rm_pop");
        rrst = 1'b1;
        #1;
        checks++;
        if ({gnt, busy, rinc, out_valid} !== 7'b0) begin
            errors++;
            $display("FAIL rm_async: got gnt=%b busy=%b rinc=%b out_valid=%b expected zeros",
                     gnt, busy, rinc, out_valid);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL rm_pending: got %0d words outstanding expected 0", sb.size());
        end
        @(posedge rclk);
        #1;
        rrst = 1'b0;
        step(1'b0, 4'b0000, 0, "rm_regrant");
        step(1'b1, 4'b0001, 0, "rm_first");
        req = '0;
        step(1'b0, 4'b0001, 0, "rm_exit");
        step(1'b0, 4'b0000, 0, "rm_idle");
    endtask

    initial begin
        test_reset();
        test_single_long();
        test_round_robin();
        test_backpressure();
        test_withdraw();
        test_empty();
        test_reset_mid_burst();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_final: got %0d unforwarded words expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/fifo_rd_arbiter.md
# fifo_rd_arbiter

Shares the read port of the asynchronous FIFO among NREQ consumers in the read clock domain. Round-robin selection grants one consumer at a time a burst of up to MAXBURST words. It drives the FIFO's rinc and honours rempty, and forwards each popped word with its consumer ID through one register stage. It sits between the FIFO read side and the downstream consumers.

## Interface
- DSIZE, 8, data word width
- NREQ, 4, number of consumers (2..16)
- MAXBURST, 8, maximum words per grant (1..256)
- rclk  in  1  read-domain clock; all logic on rising edge
- rrst  in  1  reset, asynchronous, active-high
- rempty  in  1  FIFO empty flag; registered on rclk by the FIFO
- rdata  in  DSIZE  FIFO read data; valid in any cycle rempty=0
- rinc  out  1  FIFO pop strobe; combinational
- req  in  NREQ  per-consumer request, level
- rdy  in  NREQ  per-consumer "can accept a word next cycle"
- gnt  out  NREQ  one-hot current grant, registered
- out_valid  out  1  forwarded word valid, registered
- out_data  out  DSIZE  forwarded word
- out_id  out  $clog2(NREQ)  consumer index of out_data
- busy  out  1  high while in BURST

## Operation
- Two states: IDLE and BURST.
- **IDLE:** if any req bit is high and rempty=0, select the requester via round-robin. The search starts at last_gnt+1 modulo NREQ and the first set req bit wins. Load gid, set gnt to one-hot(gid), clear cnt, go to BURST. Otherwise stay in IDLE.
- **Pop condition in BURST:** rinc = (state==BURST) & ~rempty & req[gid] & rdy[gid]. rinc is never high in IDLE.
- **Each pop:** capture rdata into out_data, set out_id=gid, and increment cnt. cnt is $clog2(MAXBURST+1) bits wide and never wraps.
- **BURST exit to IDLE** happens at the clock edge when any of these holds:
  - a pop occurs with cnt==MAXBURST-1 (burst complete);
  - req[gid]=0 (consumer withdrew);
  - rempty=1 (FIFO drained).
  - On exit: gnt clears, last_gnt<=gid.
- **Stall:** rdy[gid]=0 with req high and rempty=0 holds BURST with no pop and no timeout.
- **Arbitration gap:** there is always one IDLE cycle between grants, so at most MAXBURST pops occur per MAXBURST+1 cycles.
- **Fairness:** a continuously requesting consumer waits at most NREQ-1 grants.

## Timing
- Reset values (asynchronous, immediate, also mid-burst): state=IDLE, gnt=0, busy=0, out_valid=0, out_data=0, out_id=0, cnt=0, last_gnt=NREQ-1, so requester 0 wins first.
- rinc is combinational from registered state, gid, and the rempty/req/rdy inputs; no internal comb loop.
- Latency: a pop in cycle t gives out_valid=1 in cycle t+1 with that word; out_valid is high exactly one cycle per pop.
- Grant latency: req rising in IDLE with rempty=0 gives gnt high the next cycle and the first pop that same cycle, if rdy is high.
- rempty deasserting in the same cycle a req arrives: arbitration uses both in that cycle.
- Last-word case: a pop that empties the FIFO is followed by rempty=1 next cycle, so BURST exits with no extra rinc.
- Reset mid-burst: rinc drops combinationally as state leaves BURST; a word popped in the reset cycle is not forwarded.

## Structure
- Package fifo_rd_arb_pkg holds:
  - the state typedef (IDLE, BURST);
  - a function computing the ID width ($clog2(NREQ), minimum 1).
- Sub-module rr_pick: combinational, with inputs req and last_gnt and outputs found and idx. It is a rotate-priority encoder, reusable elsewhere.
- Top level holds the FSM, cnt, gid/last_gnt registers and output register stage.

## Test plan
- **Single consumer, long burst.** Setup: NREQ=4, MAXBURST=8, FIFO preloaded with 20 words, req=0001, rdy all high. Expected: 8 pops, 1 idle cycle, 8 pops, 1 idle cycle, 4 pops, then IDLE on rempty. out_id=0 throughout, data in order.
- **Round robin.** Setup: req=1111 constant, FIFO always non-empty. Expected: grants 0,1,2,3,0 with 8 words each; out_id sequence matches.
- **Backpressure.** Setup: during a grant to consumer 2, drop rdy[2] for 5 cycles. Expected: rinc=0 for those cycles; gnt stays 0100; the burst resumes and completes 8 words total.
- **Request withdrawal and empty.** Setup: drop req[1] after 3 pops. Expected: exit at that edge with exactly 3 words for ID 1, next grant goes to ID 2. Separately, a FIFO holding 2 words gives 2 pops and then IDLE.
- **Async reset mid-burst.** Setup: assert rrst after 4 pops for an asynchronous pulse. Expected: gnt, busy, rinc and out_valid all go to 0 immediately. After release with req=1111, the first grant goes to ID 0.
